mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port synchronous word SRAM between the pipeline's instruction-fetch port and the memory-stage load/store port. Performs fixed-priority arbitration with a starvation bound, drives the SRAM, and routes each read response back to its requester one cycle later. Sits between the processor core and the unified program/data SRAM; the core stalls the requester whose `*_ready` is low.

## Interface
- `ADDR_WIDTH`, default 14: SRAM word-address width.
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while fetch waits, range 1–15.
- `clock`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `fetch_req`  in  1  fetch read request; held until accepted.
- `fetch_addr`  in  32  fetch byte address.
- `fetch_ready`  out  1  fetch request accepted this cycle.
- `fetch_rvalid`  out  1  fetch read data valid.
- `fetch_rdata`  out  32  fetch read data.
- `data_req`  in  1  load/store request; held until accepted.
- `data_we`  in  1  1 = store, 0 = load.
- `data_be`  in  4  store byte enables.
- `data_addr`  in  32  data byte address.
- `data_wdata`  in  32  store data.
- `data_ready`  out  1  data request accepted this cycle.
- `data_rvalid`  out  1  load data valid.
- `data_rdata`  out  32  load data.
- `sram_en`  out  1  SRAM access strobe.
- `sram_we`  out  4  SRAM byte write enables; 0 for reads.
- `sram_addr`  out  ADDR_WIDTH  SRAM word address, taken from `addr[ADDR_WIDTH+1:2]`. Upper bits are ignored, so addresses wrap.
- `sram_wdata`  out  32  SRAM write data.
- `sram_rdata`  in  32  SRAM read data, valid the cycle after a read strobe.
- `fault`  out  1  one-cycle pulse: misaligned request was dropped.
- `fault_addr`  out  32  address of the last faulting request.

## Operation
**Grant logic (combinational)**
- Grant goes to data if `data_req`, unless the starve counter equals `STARVE_LIMIT` and `fetch_req` is high; in that case fetch wins.
- Otherwise grant goes to fetch if `fetch_req`; otherwise no grant.
- The granted port's `*_ready` is 1; the other port's `*_ready` is 0.
- `sram_en` is 1 for a granted aligned request.
- `sram_we` equals `data_be` for an aligned granted store; it is 0 otherwise.
- `sram_addr` and `sram_wdata` reflect the granted request. When there is no grant they hold 0.

**Starve counter (4 bits)**
- Increments when data is granted while `fetch_req` is high.
- Clears on any fetch grant, and on any cycle with `fetch_req` low.
- Saturates at `STARVE_LIMIT`.

**Response routing**
- The owner register records the owner of each granted aligned read: NONE, FETCH or DATA. Stores record NONE.
- The cycle after a read, the owner's `*_rvalid` is 1 and its `*_rdata` equals `sram_rdata`.
- The other port's `rdata` holds 0.

**Misalignment**
- A request with `addr[1:0] != 0` is still granted (ready = 1) so the requester does not hang, but `sram_en` stays 0.
- The cycle after, `fault` pulses and `fault_addr` captures the address.
- No `rvalid` is produced for a dropped request.
- `fault_addr` holds its value until the next fault.
- Fetch requests never write. `data_we` applies only to data grants.

## Timing
- Arbitration and SRAM drive are combinational in request cycle N.
- Read data is returned in cycle N+1; there is 1 cycle of read latency.
- Store completion is implied by ready in cycle N.
- Back-to-back grants are allowed every cycle. Throughput is 1 access/cycle.
- Simultaneous requests: data wins, except on the starvation-forced cycle.
- Worst-case fetch wait is `STARVE_LIMIT` cycles.
- Reset values: owner NONE, counter 0, all `*_rvalid` 0, all `rdata` 0, `fault` 0, `fault_addr` 0.
- Combinational outputs are 0 whenever `reset` is high.
- Reset in cycle N+1 of an in-flight read: no `rvalid` is produced, and the response is discarded.
- A request dropped while `reset` is high is not accepted.

## Structure
- Package `mem_arb_pkg` holds:
  - the owner enum (OWNER_NONE, OWNER_FETCH, OWNER_DATA);
  - the `WORD_BYTES` = 4 constant;
  - the default `ADDR_WIDTH` and `STARVE_LIMIT`.
- Sub-module `mem_arb_starve_counter`, which holds the saturating counter. It takes `fetch_waiting` and `data_granted` as inputs and produces `force_fetch` as output.
- Top-level contents:
  - grant mux;
  - SRAM drive;
  - owner and response registers;
  - fault capture.

## Test plan
- Fetch-only reads of 0x0, 0x4, 0x8 on consecutive cycles, with SRAM preloaded with word = index:
  - `fetch_ready` = 1 each cycle;
  - `fetch_rvalid` in cycles 1–3 with `fetch_rdata` 0, 1, 2;
  - `data_rvalid` stays 0.
- Simultaneous requests, fetch at 0x10 and a data load at 0x20:
  - `data_ready` = 1 and `fetch_ready` = 0 in cycle 0;
  - fetch is granted in cycle 1;
  - `rvalid`s arrive in order: data, then fetch.
- Continuous data requests with `fetch_req` held, `STARVE_LIMIT` = 4:
  - data granted 4 cycles, then fetch granted on the 5th;
  - counter back to 0, and data resumes.
- Store to 0x24 with `data_be` = 4'b0011 and wdata 0xAABBCCDD, over an old value of 0x11223344:
  - `sram_we` = 0011, no `rvalid`;
  - a subsequent load returns 0x1122CCDD.
- Data load at 0x22 (misaligned):
  - `data_ready` = 1 and `sram_en` = 0;
  - the next cycle `fault` = 1, `fault_addr` = 0x22, `data_rvalid` = 0.
- Fetch read granted in cycle N, with `reset` asserted in N+1:
  - `fetch_rvalid` = 0;
  - all outputs are at reset values in N+1 and N+2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data SRAM arbiter.
//   owner_e          : which port owns the read response in flight
//   WORD_BYTES       : SRAM word size in bytes
//   DEF_ADDR_WIDTH   : default SRAM word-address width
//   DEF_STARVE_LIMIT : default max consecutive data grants while fetch waits
package mem_arb_pkg;

  localparam int WORD_BYTES       = 4;
  localparam int DEF_ADDR_WIDTH   = 14;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_FETCH = 2'd1,
    OWNER_DATA  = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_starve_counter.sv
// mem_arb_starve_counter: counts consecutive data grants taken while fetch is
// waiting, saturating at STARVE_LIMIT.
//   clock, reset   : clock, synchronous active-high reset
//   fetch_waiting  : fetch request pending this cycle
//   data_granted   : data port won arbitration this cycle
//   force_fetch    : fetch must win this cycle (limit reached and fetch waits)
module mem_arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clock,
  input  logic reset,
  input  logic fetch_waiting,
  input  logic data_granted,
  output logic force_fetch
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] count;

  // A data grant with fetch waiting is the only way to advance; anything else
  // (fetch idle, or fetch itself granted) restarts the window.
  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (!fetch_waiting || !data_granted)
      count <= '0;
    else if (count != LIMIT)
      count <= count + 4'd1;
  end

  // Depends only on state and fetch_waiting, so no loop through data_granted.
  assign force_fetch = fetch_waiting && (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch port and the load/store port. Data has priority, with a
// starvation bound that forces a fetch grant after STARVE_LIMIT data grants.
// Read data returns one cycle after the grant, routed to the owning port.
//   clock, reset                 : clock, synchronous active-high reset
//   fetch_req/addr               : fetch read request (held until ready)
//   fetch_ready/rvalid/rdata     : fetch accept, read response
//   data_req/we/be/addr/wdata    : load/store request (held until ready)
//   data_ready/rvalid/rdata      : data accept, load response
//   sram_en/we/addr/wdata/rdata  : SRAM interface (rdata valid cycle after en)
//   fault, fault_addr            : misaligned-drop pulse and its address
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_rvalid,
  output logic [31:0]           fetch_rdata,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [3:0]            data_be,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           data_wdata,
  output logic                  data_ready,
  output logic                  data_rvalid,
  output logic [31:0]           data_rdata,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata,
  output logic                  fault,
  output logic [31:0]           fault_addr
);

  localparam int OFF_W = $clog2(WORD_BYTES);

  logic        force_fetch;
  logic        grant_data;
  logic        grant_fetch;
  logic        granted;
  logic [31:0] gnt_addr;
  logic        misaligned;
  owner_e      owner_next;
  owner_e      owner_q;
  logic        fault_q;
  logic [31:0] fault_addr_q;
  logic        unused_addr_bits;

  mem_arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock         (clock),
    .reset         (reset),
    .fetch_waiting (fetch_req),
    .data_granted  (grant_data),
    .force_fetch   (force_fetch)
  );

  // Grants are masked during reset so nothing is accepted then.
  assign grant_data  = !reset && data_req && !force_fetch;
  assign grant_fetch = !reset && fetch_req && !grant_data;
  assign granted     = grant_data || grant_fetch;

  assign gnt_addr   = grant_data  ? data_addr  :
                      grant_fetch ? fetch_addr : 32'd0;
  assign misaligned = granted && (gnt_addr[OFF_W-1:0] != '0);

  assign fetch_ready = grant_fetch;
  assign data_ready  = grant_data;

  // Misaligned requests are acknowledged but never reach the SRAM.
  assign sram_en    = granted && !misaligned;
  assign sram_we    = (sram_en && grant_data && data_we) ? data_be : 4'd0;
  assign sram_addr  = gnt_addr[ADDR_WIDTH+OFF_W-1:OFF_W];
  assign sram_wdata = grant_data ? data_wdata : 32'd0;

  // Upper address bits wrap by design.
  assign unused_addr_bits = ^gnt_addr;

  always_comb begin
    owner_next = OWNER_NONE;
    if (sram_en && grant_fetch)
      owner_next = OWNER_FETCH;
    else if (sram_en && grant_data && !data_we)
      owner_next = OWNER_DATA;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q      <= OWNER_NONE;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      owner_q <= owner_next;
      fault_q <= misaligned;
      if (misaligned)
        fault_addr_q <= gnt_addr;
    end
  end

  // Responses are masked by reset so a read whose data cycle coincides with
  // reset is discarded rather than delivered.
  assign fetch_rvalid = !reset && (owner_q == OWNER_FETCH);
  assign data_rvalid  = !reset && (owner_q == OWNER_DATA);
  assign fetch_rdata  = fetch_rvalid ? sram_rdata : 32'd0;
  assign data_rdata   = data_rvalid  ? sram_rdata : 32'd0;
  assign fault        = !reset && fault_q;
  assign fault_addr   = reset ? 32'd0 : fault_addr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready, fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_ready, data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        fault;
  logic [31:0] fault_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_f[$];
  logic [31:0] exp_d[$];
  logic [31:0] mem [0:16383];

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_ready(data_ready),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clock = ~clock;

  // Single-port synchronous SRAM model with byte enables.
  always @(posedge clock) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      sram_rdata <= mem[sram_addr];
    end
  end

  // Mid-cycle sample point; drains the response scoreboard.
  task automatic at_neg();
    logic [31:0] e;
    @(negedge clock);
    checks++;
    if (fetch_rvalid === 1'b1) begin
      if (exp_f.size() == 0) begin
        errors++; $display("FAIL fetch_rvalid unexpected got rdata %h exp no response", fetch_rdata);
      end else begin
        e = exp_f.pop_front();
        if (fetch_rdata !== e) begin
          errors++; $display("FAIL fetch_rdata got %h exp %h", fetch_rdata, e);
        end
      end
    end else if (fetch_rdata !== 32'd0) begin
      errors++; $display("FAIL fetch_rdata_idle got %h exp 0", fetch_rdata);
    end
    checks++;
    if (data_rvalid === 1'b1) begin
      if (exp_d.size() == 0) begin
        errors++; $display("FAIL data_rvalid unexpected got rdata %h exp no response", data_rdata);
      end else begin
        e = exp_d.pop_front();
        if (data_rdata !== e) begin
          errors++; $display("FAIL data_rdata got %h exp %h", data_rdata, e);
        end
      end
    end else if (data_rdata !== 32'd0) begin
      errors++; $display("FAIL data_rdata_idle got %h exp 0", data_rdata);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    fetch_req = 0; data_req = 0; data_we = 0; data_be = 0;
    fetch_addr = 0; data_addr = 0; data_wdata = 0;
  endtask

  task automatic queues_empty(input string name);
    checks++;
    if (exp_f.size() != 0 || exp_d.size() != 0) begin
      errors++;
      $display("FAIL %s missing responses got fetch %0d data %0d pending exp 0", name, exp_f.size(), exp_d.size());
      exp_f.delete(); exp_d.delete();
    end
  endtask

  task automatic grant_chk(input string name, input logic ef, input logic ed);
    checks++;
    if (fetch_ready !== ef || data_ready !== ed) begin
      errors++;
      $display("FAIL %s ready got f%b d%b exp f%b d%b", name, fetch_ready, data_ready, ef, ed);
    end
  endtask

  task automatic test_reset();
    reset = 1; fetch_req = 1; data_req = 1; fetch_addr = 32'h4; data_addr = 32'h8;
    at_neg();
    grant_chk("reset_ready", 0, 0);
    checks++;
    if (sram_en !== 0 || sram_we !== 0 || sram_addr !== 0 || sram_wdata !== 0) begin
      errors++; $display("FAIL reset_sram got en%b we%b addr%h exp 0", sram_en, sram_we, sram_addr);
    end
    checks++;
    if (fault !== 0 || fault_addr !== 0 || fetch_rvalid !== 0 || data_rvalid !== 0) begin
      errors++; $display("FAIL reset_regs got fault%b addr%h fv%b dv%b exp 0", fault, fault_addr, fetch_rvalid, data_rvalid);
    end
    next_cycle();
    idle(); reset = 0;
    at_neg(); next_cycle();
    queues_empty("reset");
  endtask

  task automatic test_fetch_only();
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1; fetch_addr = 32'(i * 4);
      exp_f.push_back(32'(i));
      at_neg();
      grant_chk($sformatf("fetch_only_%0d", i), 1, 0);
      next_cycle();
    end
    idle();
    at_neg(); next_cycle();
    queues_empty("fetch_only");
  endtask

  task automatic test_priority();
    fetch_req = 1; fetch_addr = 32'h10; data_req = 1; data_addr = 32'h20;
    exp_d.push_back(32'd8);
    at_neg();
    grant_chk("prio_c0", 0, 1);
    checks++;
    if (sram_addr !== 14'd8) begin
      errors++; $display("FAIL prio_sram_addr got %h exp 8", sram_addr);
    end
    next_cycle();
    data_req = 0;
    exp_f.push_back(32'd4);
    at_neg();
    grant_chk("prio_c1", 1, 0);
    checks++;
    if (data_rvalid !== 1 || fetch_rvalid !== 0) begin
      errors++; $display("FAIL prio_order c1 got dv%b fv%b exp dv1 fv0", data_rvalid, fetch_rvalid);
    end
    next_cycle();
    idle();
    at_neg();
    checks++;
    if (fetch_rvalid !== 1 || data_rvalid !== 0) begin
      errors++; $display("FAIL prio_order c2 got dv%b fv%b exp dv0 fv1", data_rvalid, fetch_rvalid);
    end
    next_cycle();
    queues_empty("priority");
  endtask

  task automatic test_starve();
    fetch_req = 1; fetch_addr = 32'h0; data_req = 1; data_addr = 32'h4;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) exp_f.push_back(32'd0);
      else        exp_d.push_back(32'd1);
      at_neg();
      grant_chk($sformatf("starve_c%0d", c), (c == 4), (c != 4));
      next_cycle();
    end
    idle();
    at_neg(); next_cycle();
    queues_empty("starve");
  endtask

  task automatic test_store();
    data_req = 1; data_we = 1; data_be = 4'b0011; data_addr = 32'h24; data_wdata = 32'hAABBCCDD;
    at_neg();
    grant_chk("store", 0, 1);
    checks++;
    if (sram_en !== 1 || sram_we !== 4'b0011 || sram_wdata !== 32'hAABBCCDD) begin
      errors++; $display("FAIL store_drive got en%b we%b wd%h exp en1 we0011 wdaabbccdd", sram_en, sram_we, sram_wdata);
    end
    next_cycle();
    data_we = 0; data_be = 0;
    exp_d.push_back(32'h1122CCDD);
    at_neg();
    checks++;
    if (sram_we !== 4'b0000) begin
      errors++; $display("FAIL load_we got %b exp 0000", sram_we);
    end
    next_cycle();
    idle();
    at_neg(); next_cycle();
    queues_empty("store");
  endtask

  task automatic test_misaligned();
    data_req = 1; data_addr = 32'h22;
    at_neg();
    grant_chk("misalign", 0, 1);
    checks++;
    if (sram_en !== 0) begin
      errors++; $display("FAIL misalign_en got %b exp 0", sram_en);
    end
    next_cycle();
    idle();
    at_neg();
    checks++;
    if (fault !== 1 || fault_addr !== 32'h22) begin
      errors++; $display("FAIL misalign_fault got %b addr %h exp 1 addr 00000022", fault, fault_addr);
    end
    next_cycle();
    at_neg();
    checks++;
    if (fault !== 0 || fault_addr !== 32'h22) begin
      errors++; $display("FAIL fault_hold got %b addr %h exp 0 addr 00000022", fault, fault_addr);
    end
    next_cycle();
    queues_empty("misaligned");
  endtask

  task automatic test_reset_inflight();
    fetch_req = 1; fetch_addr = 32'h8;
    at_neg();
    grant_chk("inflight_grant", 1, 0);
    next_cycle();
    idle(); reset = 1;
    for (int c = 1; c <= 2; c++) begin
      if (c == 2) reset = 0;
      at_neg();
      checks++;
      if (fetch_rvalid !== 0 || data_rvalid !== 0 || fault !== 0 || fault_addr !== 0 || sram_en !== 0) begin
        errors++;
        $display("FAIL inflight_n%0d got fv%b dv%b fault%b faddr%h en%b exp all 0", c, fetch_rvalid, data_rvalid, fault, fault_addr, sram_en);
      end
      next_cycle();
    end
    queues_empty("reset_inflight");
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'(i);
    mem[9] = 32'h11223344;
    test_reset();
    test_fetch_only();
    test_priority();
    test_starve();
    test_store();
    test_misaligned();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
